// File: rtl/miriscv_mem_arb_pkg.sv
// Shared types for the instruction/data memory-port arbiter.
package miriscv_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } arb_owner_e;

  localparam int unsigned STREAK_W = 4;

endpackage

// File: rtl/miriscv_mem_arb_prio.sv
// Winner select for the shared memory port: data has priority, but an
// instruction fetch is forced through after MAX_DATA_STREAK data grants.
module miriscv_mem_arb_prio
  import miriscv_mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic instr_req,
  input  logic data_req,
  input  logic arb_en,
  output logic grant_data
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;
  logic                streak_sat;

  assign streak_sat = (streak_q >= STREAK_MAX);
  assign grant_data = data_req & (~instr_req | ~streak_sat);

  // Streak only moves when an arbitration actually takes place.
  always_comb begin
    streak_d = streak_q;
    if (arb_en && (instr_req || data_req)) begin
      if (grant_data && instr_req) begin
        if (streak_sat) begin
          streak_d = streak_q;
        end else begin
          streak_d = streak_q + STREAK_W'(1);
        end
      end else begin
        streak_d = {STREAK_W{1'b0}};
      end
    end else begin
      streak_d = streak_q;
    end
  end

  // Streak counter register.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      streak_q <= {STREAK_W{1'b0}};
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// Shares one downstream memory port between the fetch and data interfaces,
// one outstanding transaction at a time.
module miriscv_mem_arbiter #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              instr_req_i,
  input  logic [XLEN-1:0]   instr_addr_i,
  output logic              instr_rvalid_o,
  output logic [XLEN-1:0]   instr_rdata_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [XLEN/8-1:0] data_be_i,
  input  logic [XLEN-1:0]   data_addr_i,
  input  logic [XLEN-1:0]   data_wdata_i,
  output logic              data_rvalid_o,
  output logic [XLEN-1:0]   data_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              busy_o,
  output logic              owner_o
);

  import miriscv_mem_arb_pkg::*;

  localparam int unsigned BE_W = XLEN / 8;

  arb_state_e       state_q, state_d;
  arb_owner_e       owner_q, owner_d;
  logic             we_q, we_d;
  logic [BE_W-1:0]  be_q, be_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic             mem_req_q, mem_req_d;
  logic             busy_q, busy_d;
  logic             arb_en;
  logic             grant_data;
  logic             complete;

  assign arb_en = (state_q == IDLE);

  miriscv_mem_arb_prio #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_prio (
    .clk_i     (clk_i),
    .arstn_i   (arstn_i),
    .instr_req (instr_req_i),
    .data_req  (data_req_i),
    .arb_en    (arb_en),
    .grant_data(grant_data)
  );

  // A response counts only once the request has been accepted.
  assign complete = mem_rvalid_i &
                    (((state_q == ISSUE) & mem_gnt_i) | (state_q == WAIT));

  // Next-state, payload latch and registered-output decode.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (instr_req_i || data_req_i) begin
          state_d = ISSUE;
          if (grant_data) begin
            owner_d = OWNER_DATA;
            we_d    = data_we_i;
            be_d    = data_be_i;
            addr_d  = data_addr_i;
            wdata_d = data_wdata_i;
          end else begin
            owner_d = OWNER_INSTR;
            we_d    = 1'b0;
            be_d    = {BE_W{1'b1}};
            addr_d  = instr_addr_i;
            wdata_d = {XLEN{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (mem_gnt_i && mem_rvalid_i) begin
          state_d = IDLE;
        end else if (mem_gnt_i) begin
          state_d = WAIT;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    mem_req_d = (state_d == ISSUE);
    busy_d    = (state_d != IDLE);
  end

  // FSM, payload and output registers.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q   <= IDLE;
      owner_q   <= OWNER_INSTR;
      we_q      <= 1'b0;
      be_q      <= {BE_W{1'b0}};
      addr_q    <= {XLEN{1'b0}};
      wdata_q   <= {XLEN{1'b0}};
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mem_req_q <= mem_req_d;
      busy_q    <= busy_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = busy_q;
  assign owner_o     = owner_q;

  // Response path is purely combinational so no latency is added.
  assign instr_rvalid_o = complete & (owner_q == OWNER_INSTR);
  assign data_rvalid_o  = complete & (owner_q == OWNER_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : {XLEN{1'b0}};
  assign data_rdata_o   = data_rvalid_o  ? mem_rdata_i : {XLEN{1'b0}};

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Bench for miriscv_mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_miriscv_mem_arbiter;

  localparam int MAX_STREAK = 4;

  logic        clk = 1'b0;
  logic        arstn_i;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;
  logic        owner_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  miriscv_mem_arbiter #(.XLEN(32), .MAX_DATA_STREAK(MAX_STREAK)) dut (
    .clk_i(clk), .arstn_i(arstn_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .owner_o(owner_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_req_i = 1'b0; instr_addr_i = 32'h0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
    data_addr_i = 32'h0; data_wdata_i = 32'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    arstn_i = 1'b0;
    tick();
    tick();
    arstn_i = 1'b1;
  endtask

  task automatic test_reset();
    arstn_i = 1'b0;
    idle_inputs();
    instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'hFFFF_FFFF;
    tick();
    @(negedge clk);
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", mem_req_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    checks++; if (owner_o !== 1'b0) begin errors++; $display("FAIL rst_owner: got %b want 0", owner_o); end
    checks++; if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== 69'h0) begin errors++; $display("FAIL rst_mem_payload: got %h want 0", {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}); end
    checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b want 00", {instr_rvalid_o, data_rvalid_o}); end
    checks++; if ({instr_rdata_o, data_rdata_o} !== 64'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", {instr_rdata_o, data_rdata_o}); end
    idle_inputs();
  endtask

  task automatic test_single_fetch();
    do_reset();
    tick(); instr_req_i = 1'b1; instr_addr_i = 32'h80; mem_gnt_i = 1'b1;
    @(negedge clk);
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL sf_c0_req: got %b want 0", mem_req_o); end
    tick(); @(negedge clk);
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL sf_c1_req: got %b want 1", mem_req_o); end
    checks++; if (mem_addr_o !== 32'h80) begin errors++; $display("FAIL sf_c1_addr: got %h want 80", mem_addr_o); end
    checks++; if ({mem_we_o, mem_be_o, mem_wdata_o} !== {1'b0, 4'hF, 32'h0}) begin errors++; $display("FAIL sf_c1_we_be: got %b/%h/%h want 0/f/0", mem_we_o, mem_be_o, mem_wdata_o); end
    checks++; if ({busy_o, owner_o} !== 2'b10) begin errors++; $display("FAIL sf_c1_busy_owner: got %b want 10", {busy_o, owner_o}); end
    tick(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0013;
    @(negedge clk);
    checks++; if ({instr_rvalid_o, instr_rdata_o} !== {1'b1, 32'h13}) begin errors++; $display("FAIL sf_c2_resp: got %b/%h want 1/13", instr_rvalid_o, instr_rdata_o); end
    checks++; if ({data_rvalid_o, mem_req_o} !== 2'b00) begin errors++; $display("FAIL sf_c2_drv_req: got %b want 00", {data_rvalid_o, mem_req_o}); end
    tick(); instr_req_i = 1'b0; mem_rvalid_i = 1'b0;
    @(negedge clk);
    checks++; if ({instr_rvalid_o, busy_o} !== 2'b00) begin errors++; $display("FAIL sf_c3_idle: got %b want 00", {instr_rvalid_o, busy_o}); end
    idle_inputs();
  endtask

  task automatic test_collision();
    do_reset();
    tick();
    instr_req_i = 1'b1; instr_addr_i = 32'h100;
    data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h2000;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_0001;
    @(negedge clk);
    checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin errors++; $display("FAIL col_idle_rvalid: got %b want 00", {instr_rvalid_o, data_rvalid_o}); end
    tick(); @(negedge clk);
    checks++; if ({mem_req_o, owner_o, mem_addr_o} !== {2'b11, 32'h2000}) begin errors++; $display("FAIL col_first: got %b%b/%h want 11/2000", mem_req_o, owner_o, mem_addr_o); end
    checks++; if ({data_rvalid_o, data_rdata_o, instr_rvalid_o} !== {1'b1, 32'hCAFE_0001, 1'b0}) begin errors++; $display("FAIL col_first_resp: got %b/%h/%b want 1/cafe0001/0", data_rvalid_o, data_rdata_o, instr_rvalid_o); end
    tick(); data_req_i = 1'b0; mem_rdata_i = 32'hCAFE_0002;
    @(negedge clk);
    checks++; if ({mem_req_o, instr_rvalid_o, data_rvalid_o} !== 3'b000) begin errors++; $display("FAIL col_bubble: got %b want 000", {mem_req_o, instr_rvalid_o, data_rvalid_o}); end
    tick(); @(negedge clk);
    checks++; if ({mem_req_o, owner_o, mem_addr_o} !== {2'b10, 32'h100}) begin errors++; $display("FAIL col_second: got %b%b/%h want 10/100", mem_req_o, owner_o, mem_addr_o); end
    checks++; if ({instr_rvalid_o, instr_rdata_o, data_rvalid_o, data_rdata_o} !== {1'b1, 32'hCAFE_0002, 1'b0, 32'h0}) begin errors++; $display("FAIL col_second_resp: got %b/%h/%b/%h want 1/cafe0002/0/0", instr_rvalid_o, instr_rdata_o, data_rvalid_o, data_rdata_o); end
    tick(); instr_req_i = 1'b0;
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL col_done_busy: got %b want 0", busy_o); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    tick();
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'hF; data_addr_i = 32'h40;
    data_wdata_i = 32'h1234_5678; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k % 2 == 0) data_addr_i = 32'h40 + 32'(k);
      @(negedge clk);
      checks++; if ({mem_req_o, busy_o, data_rvalid_o} !== {3{k % 2 == 1}}) begin errors++; $display("FAIL b2b_pattern c%0d: got %b want %b", k, {mem_req_o, busy_o, data_rvalid_o}, {3{k % 2 == 1}}); end
      if (k % 2 == 1) begin
        checks++; if (mem_addr_o !== 32'h40 + 32'(k - 1)) begin errors++; $display("FAIL b2b_addr c%0d: got %h want %h", k, mem_addr_o, 32'h40 + 32'(k - 1)); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_starvation();
    do_reset();
    tick();
    instr_req_i = 1'b1; instr_addr_i = 32'h200;
    data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h3000;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(); @(negedge clk);
      checks++; if (mem_req_o !== (k % 2 == 1)) begin errors++; $display("FAIL starv_req c%0d: got %b want %b", k, mem_req_o, (k % 2 == 1)); end
      if (k % 2 == 1) begin
        checks++; if (owner_o !== (((k - 1) / 2) % 5 != 4)) begin errors++; $display("FAIL starv_owner t%0d: got %b want %b", (k - 1) / 2, owner_o, (((k - 1) / 2) % 5 != 4)); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_grant_stall();
    do_reset();
    tick();
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'h3; data_addr_i = 32'h10;
    data_wdata_i = 32'hDEAD_BEEF;
    for (int k = 1; k <= 5; k++) begin
      tick();
      data_addr_i = $urandom; data_wdata_i = $urandom; data_be_i = 4'($urandom);
      mem_rvalid_i = (k == 3); mem_rdata_i = $urandom;
      @(negedge clk);
      checks++; if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {2'b11, 4'h3, 32'h10, 32'hDEAD_BEEF}) begin errors++; $display("FAIL stall_stable c%0d: got %b%b/%h/%h/%h", k, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o); end
      checks++; if (data_rvalid_o !== 1'b0) begin errors++; $display("FAIL stall_rvalid c%0d: got %b want 0", k, data_rvalid_o); end
    end
    tick(); mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0;
    @(negedge clk);
    checks++; if ({mem_req_o, data_rvalid_o} !== 2'b10) begin errors++; $display("FAIL stall_gnt: got %b want 10", {mem_req_o, data_rvalid_o}); end
    tick(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5A5A_5A5A;
    @(negedge clk);
    checks++; if ({mem_req_o, data_rvalid_o, data_rdata_o} !== {2'b01, 32'h5A5A_5A5A}) begin errors++; $display("FAIL stall_resp: got %b%b/%h want 01/5a5a5a5a", mem_req_o, data_rvalid_o, data_rdata_o); end
    tick(); data_req_i = 1'b0; mem_rvalid_i = 1'b0;
    @(negedge clk);
    checks++; if ({data_rvalid_o, busy_o} !== 2'b00) begin errors++; $display("FAIL stall_after: got %b want 00", {data_rvalid_o, busy_o}); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick();
    instr_req_i = 1'b1; instr_addr_i = 32'h300;
    data_req_i = 1'b1; data_be_i = 4'hF; data_addr_i = 32'h4000;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    mem_rvalid_i = 1'b0;
    tick(); @(negedge clk);
    checks++; if ({mem_req_o, owner_o} !== 2'b11) begin errors++; $display("FAIL rmid_issue: got %b want 11", {mem_req_o, owner_o}); end
    tick(); arstn_i = 1'b0; idle_inputs();
    @(negedge clk);
    checks++; if ({busy_o, mem_req_o} !== 2'b00) begin errors++; $display("FAIL rmid_in_reset: got %b want 00", {busy_o, mem_req_o}); end
    tick(); arstn_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777_7777;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if ({instr_rvalid_o, data_rvalid_o, busy_o} !== 3'b000) begin errors++; $display("FAIL rmid_quiet c%0d: got %b want 000", k, {instr_rvalid_o, data_rvalid_o, busy_o}); end
      tick();
    end
    instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(); @(negedge clk);
      if (k % 2 == 1) begin
        checks++; if ({mem_req_o, owner_o} !== {1'b1, (k != 9)}) begin errors++; $display("FAIL rmid_streak t%0d: got %b want %b", (k - 1) / 2, {mem_req_o, owner_o}, {1'b1, (k != 9)}); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    bit          m_issue, m_out, m_owner, m_we, i_got, d_got, comp, free, exp_irv, exp_drv;
    int          m_streak;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    do_reset();
    m_issue = 0; m_out = 0; m_owner = 0; m_we = 0; m_streak = 0;
    m_addr = 32'h0; m_wdata = 32'h0; m_be = 4'h0; i_got = 0; d_got = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (instr_req_i ? i_got : ($urandom_range(0, 99) < 40)) begin
        instr_req_i = instr_req_i ? ($urandom_range(0, 99) < 60) : 1'b1;
        instr_addr_i = $urandom & 32'hFFFF_FFFC;
      end
      if (data_req_i ? d_got : ($urandom_range(0, 99) < 40)) begin
        data_req_i = data_req_i ? ($urandom_range(0, 99) < 60) : 1'b1;
        data_we_i = 1'($urandom); data_be_i = 4'($urandom_range(1, 15));
        data_addr_i = $urandom; data_wdata_i = $urandom;
      end
      if ((m_issue || m_out) && !m_owner && !i_got && ($urandom_range(0, 99) < 20)) instr_addr_i = $urandom;
      if ((m_issue || m_out) && m_owner && !d_got && ($urandom_range(0, 99) < 20)) data_wdata_i = $urandom;
      mem_gnt_i = m_issue ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 30);
      mem_rvalid_i = m_out ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 40);
      mem_rdata_i = $urandom;
      @(negedge clk);
      comp = mem_rvalid_i && ((m_issue && mem_gnt_i) || m_out);
      exp_irv = comp && !m_owner;
      exp_drv = comp && m_owner;
      checks++; if ({mem_req_o, busy_o} !== {m_issue, m_issue || m_out}) begin errors++; $display("FAIL rnd_req_busy c%0d: got %b want %b", cyc, {mem_req_o, busy_o}, {m_issue, m_issue || m_out}); end
      if (m_issue || m_out) begin
        checks++; if (owner_o !== m_owner) begin errors++; $display("FAIL rnd_owner c%0d: got %b want %b", cyc, owner_o, m_owner); end
      end
      if (m_issue) begin
        checks++; if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {m_we, m_be, m_addr, m_wdata}) begin errors++; $display("FAIL rnd_payload c%0d: got %b/%h/%h/%h want %b/%h/%h/%h", cyc, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, m_we, m_be, m_addr, m_wdata); end
      end
      checks++; if ({instr_rvalid_o, instr_rdata_o} !== {exp_irv, exp_irv ? mem_rdata_i : 32'h0}) begin errors++; $display("FAIL rnd_instr_resp c%0d: got %b/%h want %b", cyc, instr_rvalid_o, instr_rdata_o, exp_irv); end
      checks++; if ({data_rvalid_o, data_rdata_o} !== {exp_drv, exp_drv ? mem_rdata_i : 32'h0}) begin errors++; $display("FAIL rnd_data_resp c%0d: got %b/%h want %b", cyc, data_rvalid_o, data_rdata_o, exp_drv); end
      i_got = exp_irv;
      d_got = exp_drv;
      free = !m_issue && !m_out;
      if (comp) begin
        m_issue = 0; m_out = 0;
      end else if (m_issue && mem_gnt_i) begin
        m_issue = 0; m_out = 1;
      end
      if (free && (instr_req_i || data_req_i)) begin
        m_issue = 1;
        if (data_req_i && (!instr_req_i || m_streak < MAX_STREAK)) begin
          m_owner = 1; m_we = data_we_i; m_be = data_be_i; m_addr = data_addr_i; m_wdata = data_wdata_i;
          m_streak = instr_req_i ? ((m_streak < MAX_STREAK) ? m_streak + 1 : MAX_STREAK) : 0;
        end else begin
          m_owner = 0; m_we = 0; m_be = 4'hF; m_addr = instr_addr_i; m_wdata = 32'h0;
          m_streak = 0;
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_collision();
    test_back_to_back();
    test_starvation();
    test_grant_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
